multiplier_iterative: RTL and testbench
=======================================

// Module: multiplier_iterative
// PURPOSE
//  Iterative radix-2 shift-add multiplier for RV32IM MUL/MULH/MULHSU/MULHU.
//  Consumes MULop and mul_valid from the multiplier decoder and rs1/rs2 from the register file.
//  Returns the 32-bit rd value with a one-cycle mul_ready pulse to the multi-cycle control FSM.
//  One result every XLEN+2 cycles; no pipelining, one operation in flight.
// PARAMETERS
//  XLEN  32  operand/result width; internal product 2*XLEN bits, step counter $clog2(XLEN) bits
// PORTS
//  clk        in   1              core clock, all state on posedge
//  resetn     in   1              synchronous active-low reset
//  rs1        in   XLEN           multiplicand, sampled at start only
//  rs2        in   XLEN           multiplier, sampled at start only
//  MULop      in   MUL_OP_WIDTH   MUL_OP_MUL/_MULH/_MULSU/_MULU (riscv_defines.svh), sampled at start
//  mul_valid  in   1              request; held high by control until mul_ready seen
//  rd         out  XLEN           result; valid only while mul_ready=1
//  mul_ready  out  1              single-cycle completion pulse
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE, mul_ready=0, rd=0, counter=0, accumulator=0.
//  FSM states IDLE -> CALC -> DONE -> IDLE.
//  IDLE: mul_valid=1 -> latch |rs1|,|rs2| (magnitudes per op), result sign, op; clear acc;
//   counter=XLEN-1; go CALC. Else stay; mul_ready=0.
//  Sign rules: MUL, MULH: rs1 and rs2 signed. MULSU: rs1 signed, rs2 unsigned.
//   MULU: both unsigned. neg = signA ^ signB. Magnitude of 0x8000_0000 as signed = 2^31 (unsigned).
//  CALC: per cycle, if mplier[0], acc += mcand << step; shift mplier right 1.
//   After the step at counter==0, go DONE. Exactly XLEN cycles in CALC.
//  DONE: prod = neg ? -acc : acc (2*XLEN-bit two's complement); mul_ready=1 for this cycle only.
//   rd = prod[XLEN-1:0] for MUL, prod[2*XLEN-1:XLEN] for MULH/MULSU/MULU. Next state IDLE.
//  Latency: mul_valid first seen high at edge T -> mul_ready=1 during cycle T+XLEN+1 (33 for XLEN=32).
//  Handshake: control drops mul_valid in the cycle after mul_ready; if mul_valid is still high in IDLE,
//   a new operation starts (back-to-back allowed, no bubble beyond IDLE cycle).
//  Abort: mul_valid=0 during CALC -> return to IDLE next edge, no mul_ready pulse, rd unchanged.
//  MULop not one of the four encodings: never reaches here with mul_valid=1 (decoder gates it);
//   if it does, treat as MUL.
//  rs1/rs2/MULop changes after start are ignored; result depends only on latched values.
//  Reset mid-CALC or in DONE: immediate return to IDLE, mul_ready=0 that cycle, rd=0.
//  rd holds last result outside DONE (no combinational path from rs1/rs2 to rd).
//  No overflow flag; all arithmetic modulo 2^(2*XLEN).
// TESTING
//  MUL rs1=3, rs2=7, valid held -> mul_ready exactly 33 cycles later, rd=0x0000_0015, pulse 1 cycle.
//  MULH rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> rd=0x0000_0000; MUL same operands -> rd=0x0000_0001.
//  MULSU rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> rd=0xFFFF_FFFF; MULU same operands -> rd=0xFFFF_FFFE.
//  MULH rs1=0x8000_0000, rs2=0x8000_0000 -> rd=0x4000_0000; MUL rs1=0x8000_0000, rs2=0xFFFF_FFFF -> rd=0x8000_0000.
//  Start MUL, drop mul_valid at CALC cycle 10 -> no mul_ready; new MULU 5x6 -> rd=0 (high), completes normally.
//  Start MULH, pull resetn low at CALC cycle 20 -> next cycle IDLE, mul_ready=0, rd=0; 1000 random ops vs model.

Source files
------------

// File: rtl/multiplier_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : multiplier_iterative
//  Purpose  : Iterative radix-2 shift-add multiplier for RV32IM
//             MUL / MULH / MULHSU / MULHU. One operation in flight,
//             one result every XLEN+2 cycles.
//  Ports    : clk        - core clock, all state on posedge
//             resetn     - synchronous active-low reset
//             rs1, rs2   - operands, sampled only when an operation starts
//             MULop      - operation select, sampled when an operation starts
//             mul_valid  - request, held high until mul_ready is seen
//             rd         - result, valid while mul_ready=1, held otherwise
//             mul_ready  - single-cycle completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module multiplier_iterative #(
    parameter int XLEN         = 32,
    parameter int MUL_OP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [XLEN-1:0]         rs1,
    input  logic [XLEN-1:0]         rs2,
    input  logic [MUL_OP_WIDTH-1:0] MULop,
    input  logic                    mul_valid,
    output logic [XLEN-1:0]         rd,
    output logic                    mul_ready
);

    localparam int CW = $clog2(XLEN);

    // Operation encodings (funct3[1:0] of the M extension multiply group)
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MUL   = MUL_OP_WIDTH'(0);
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULH  = MUL_OP_WIDTH'(1);
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULSU = MUL_OP_WIDTH'(2);
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULU  = MUL_OP_WIDTH'(3);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     counter;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;    // shifted left each step, so it always holds mcand << step
    logic [XLEN-1:0]   mplier;
    logic              neg;
    logic              op_hi;    // result comes from the upper half of the product

    logic              sign_a;
    logic              sign_b;
    logic              hi_sel;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rd_next;

    // Operand signedness and result half per operation; unknown codes act as MUL.
    always_comb begin
        sign_a = rs1[XLEN-1];
        sign_b = rs2[XLEN-1];
        hi_sel = 1'b0;
        case (MULop)
            MUL_OP_MULH: begin
                hi_sel = 1'b1;
            end
            MUL_OP_MULSU: begin
                sign_b = 1'b0;
                hi_sel = 1'b1;
            end
            MUL_OP_MULU: begin
                sign_a = 1'b0;
                sign_b = 1'b0;
                hi_sel = 1'b1;
            end
            default: begin
                hi_sel = 1'b0;
            end
        endcase
    end

    // Magnitudes; the most negative value maps to 2^(XLEN-1) read as unsigned.
    assign mag_a = sign_a ? (~rs1 + XLEN'(1)) : rs1;
    assign mag_b = sign_b ? (~rs2 + XLEN'(1)) : rs2;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // The final sign fix-up is taken from the last step's sum so rd is already
    // registered and stable for the whole cycle mul_ready is high.
    assign prod    = neg ? (~acc_next + (2*XLEN)'(1)) : acc_next;
    assign rd_next = op_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            counter   <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            op_hi     <= 1'b0;
            rd        <= '0;
            mul_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mul_ready <= 1'b0;
                    if (mul_valid) begin
                        mcand   <= {{XLEN{1'b0}}, mag_a};
                        mplier  <= mag_b;
                        neg     <= sign_a ^ sign_b;
                        op_hi   <= hi_sel;
                        acc     <= '0;
                        counter <= CW'(XLEN - 1);
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!mul_valid) begin
                        // Aborted by control: drop the operation, keep rd.
                        state <= S_IDLE;
                    end else begin
                        acc     <= acc_next;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        counter <= counter - CW'(1);
                        if (counter == '0) begin
                            rd        <= rd_next;
                            mul_ready <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    mul_ready <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    mul_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplier_iterative
//  Purpose  : Self-checking bench for multiplier_iterative: reset state,
//             latency and pulse width, sign rules, abort, reset mid-operation,
//             back-to-back operation and random operations against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multiplier_iterative;

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULH  = 2'd1;
    localparam logic [1:0] OP_MULSU = 2'd2;
    localparam logic [1:0] OP_MULU  = 2'd3;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  MULop;
    logic        mul_valid;
    logic [31:0] rd;
    logic        mul_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multiplier_iterative #(.XLEN(32), .MUL_OP_WIDTH(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rs1       (rs1),
        .rs2       (rs2),
        .MULop     (MULop),
        .mul_valid (mul_valid),
        .rd        (rd),
        .mul_ready (mul_ready)
    );

    // Reference: 64-bit product of the sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == OP_MULU) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (op == OP_MUL || op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Starts an operation, scrambles the inputs right after the start edge,
    // and returns the result and the clock period in which mul_ready appeared.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        MULop = op; rs1 = a; rs2 = b; mul_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        res = 32'hxxxx_xxxx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rs1 = $urandom; rs2 = $urandom; MULop = 2'($urandom);
            end
            if (mul_ready === 1'b1) begin
                lat = i;
                res = rd;
                break;
            end
        end
        mul_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; mul_valid = 1'b0; rs1 = 32'h1234_5678; rs2 = 32'h9; MULop = OP_MUL;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mul_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", mul_ready); end
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 00000000", rd); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (mul_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", mul_ready); end
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] res;
        @(negedge clk);
        MULop = OP_MUL; rs1 = 32'd3; rs2 = 32'd7; mul_valid = 1'b1;
        @(posedge clk);
        lat = 0; res = 32'hxxxx_xxxx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (mul_ready === 1'b1) begin lat = i; res = rd; break; end
        end
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", lat); end
        n_cmp++;
        if (res !== 32'h0000_0015) begin n_fail++; $display("FAIL basic_rd: got %h want 00000015", res); end
        // valid still held: pulse must end after one cycle, rd must hold
        @(negedge clk);
        n_cmp++;
        if (mul_ready !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 0", mul_ready); end
        mul_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd !== 32'h0000_0015) begin n_fail++; $display("FAIL basic_rd_hold: got %h want 00000015", rd); end
        n_cmp++;
        if (mul_ready !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", mul_ready); end
    endtask

    task automatic test_signs();
        logic [1:0]  ops [6] = '{OP_MULH, OP_MUL, OP_MULSU, OP_MULU, OP_MULH, OP_MUL};
        logic [31:0] va  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exp [6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'h8000_0000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], va[i], vb[i], res, lat);
            n_cmp++;
            if (res !== exp[i]) begin
                n_fail++;
                $display("FAIL signs_%0d rd: op=%0d a=%h b=%h got %h want %h", i, ops[i], va[i], vb[i], res, exp[i]);
            end
            n_cmp++;
            if (lat !== 33) begin n_fail++; $display("FAIL signs_%0d latency: got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int lat;
        bit saw;
        // rd holds 0x8000_0000 from the last sign vector
        @(negedge clk);
        MULop = OP_MUL; rs1 = 32'h0000_1234; rs2 = 32'h0000_0010; mul_valid = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        mul_valid = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mul_ready !== 1'b0) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got pulse want none"); end
        n_cmp++;
        if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL abort_rd_hold: got %h want 80000000", rd); end
        run_op(OP_MULU, 32'd5, 32'd6, res, lat);
        n_cmp++;
        if (res !== 32'h0) begin n_fail++; $display("FAIL abort_next_rd: got %h want 00000000", res); end
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 33", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat;
        bit saw;
        run_op(OP_MUL, 32'd5, 32'd6, res, lat);
        n_cmp++;
        if (res !== 32'd30) begin n_fail++; $display("FAIL rstmid_pre_rd: got %h want 0000001e", res); end
        @(negedge clk);
        MULop = OP_MULH; rs1 = 32'h7FFF_FFFF; rs2 = 32'h7FFF_FFFF; mul_valid = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mul_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", mul_ready); end
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_rd: got %h want 00000000", rd); end
        resetn = 1'b1;
        mul_valid = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mul_ready !== 1'b0) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got pulse want none"); end
        run_op(OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, res, lat);
        n_cmp++;
        if (res !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL rstmid_after_rd: got %h want 3fffffff", res); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        logic [31:0] res;
        @(negedge clk);
        MULop = OP_MUL; rs1 = 32'd3; rs2 = 32'd7; mul_valid = 1'b1;
        @(posedge clk);
        res = 32'hxxxx_xxxx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (mul_ready === 1'b1) begin res = rd; break; end
        end
        n_cmp++;
        if (res !== 32'h0000_0015) begin n_fail++; $display("FAIL b2b_first_rd: got %h want 00000015", res); end
        // valid stays high: next op starts from the IDLE cycle right after DONE
        MULop = OP_MULU; rs1 = 32'hFFFF_FFFF; rs2 = 32'd2;
        cnt = 0; res = 32'hxxxx_xxxx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (mul_ready === 1'b1) begin cnt = i; res = rd; break; end
        end
        mul_valid = 1'b0;
        n_cmp++;
        if (cnt !== 34) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 34", cnt); end
        n_cmp++;
        if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_second_rd: got %h want 00000001", res); end
    endtask

    task automatic test_random();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001};
        logic [31:0] a, b, res, exp;
        logic [1:0] op;
        int lat;
        int shown = 0;
        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            exp = model(op, a, b);
            run_op(op, a, b, res, lat);
            n_cmp++;
            if (res !== exp || lat !== 33) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_%0d: op=%0d a=%h b=%h got %h lat %0d want %h lat 33", i, op, a, b, res, lat, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
